resilient_stage_ctrl: RTL and testbench



---
 rtl/resilient_stage_ctrl_pkg.sv | 24 ++
 rtl/resilient_stage_ctrl_if.sv | 32 +++
 rtl/resilient_stage_ctrl_fifo.sv | 49 ++++
 rtl/resilient_stage_ctrl.sv | 175 +++++++++++++++++
 tb/tb_resilient_stage_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/resilient_stage_ctrl_pkg.sv
// Shared types and helpers for the timing-resilient stage controller.
package resilient_pkg;

    typedef enum logic [2:0] {
        L_IDLE,
        L_CAPT,
        L_EVAL,
        L_CORR,
        L_PUSH,
        L_ACK
    } lstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RTZ
    } rstate_t;

    // Bits needed to count 0..err_wait inclusive.
    function automatic int unsigned wcnt_w(input int unsigned err_wait);
        return $clog2(err_wait + 1);
    endfunction

endpackage

// File: rtl/resilient_stage_ctrl_if.sv
// Left/right handshake, error rails and status of one resilient stage.
interface resilient_stage_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
) ();
    logic             Lreq;
    logic             Lack;
    logic [WIDTH-1:0] Ldata;
    logic [WIDTH-1:0] Sdata;
    logic [LANES-1:0] err_t;
    logic [LANES-1:0] err_f;
    logic             cap_en;
    logic             sample;
    logic             Rreq;
    logic             Rack;
    logic [WIDTH-1:0] Rdata;
    logic             err_clr;
    logic [CNT_W-1:0] err_cnt;
    logic             to_evt;
    logic             busy;

    modport master (
        output Lreq, Ldata, Sdata, err_t, err_f, Rack, err_clr,
        input  Lack, cap_en, sample, Rreq, Rdata, err_cnt, to_evt, busy
    );

    modport slave (
        input  Lreq, Ldata, Sdata, err_t, err_f, Rack, err_clr,
        output Lack, cap_en, sample, Rreq, Rdata, err_cnt, to_evt, busy
    );
endinterface

// File: rtl/resilient_stage_ctrl_fifo.sv
// DEPTH x WIDTH synchronous FIFO; writes when full and reads when empty are ignored.
module hs_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_cnt == (AW + 1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wr_data;
    end
endmodule

// File: rtl/resilient_stage_ctrl.sv
// Timing-resilient stage controller: left capture/evaluate/correct FSM, output FIFO,
// and right return-to-zero handshake FSM.
module resilient_stage_ctrl
    import resilient_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LANES    = 4,
    parameter int unsigned ERR_WAIT = 3,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = 16
) (
    input logic                   clk,
    input logic                   rst,
    resilient_stage_ctrl_if.slave bus
);
    localparam int unsigned     WCW   = wcnt_w(ERR_WAIT);
    localparam logic [WCW-1:0] WLAST = WCW'(ERR_WAIT - 1);

    lstate_t          r_lst, w_lst_d;
    rstate_t          r_rst, w_rst_d;
    logic             r_lreq;
    logic [WIDTH-1:0] r_stage, w_stage_d;
    logic [WCW-1:0]   r_wcnt, w_wcnt_d;
    logic             r_lack, w_lack_d;
    logic             r_cap, r_smp, r_to, w_to_d;
    logic [CNT_W-1:0] r_cnt;
    logic             w_inc, w_push, w_pop;
    logic             r_rreq, w_rreq_d;
    logic [WIDTH-1:0] r_rdata, w_rdata_d;
    logic [WIDTH-1:0] w_head;
    logic             w_full, w_empty;
    logic             w_all_res, w_any_err;

    assign w_all_res = &(bus.err_t | bus.err_f);
    assign w_any_err = |bus.err_t;

    hs_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (r_stage),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_comb begin
        w_lst_d   = r_lst;
        w_stage_d = r_stage;
        w_wcnt_d  = r_wcnt;
        w_lack_d  = r_lack;
        w_to_d    = 1'b0;
        w_inc     = 1'b0;
        w_push    = 1'b0;
        case (r_lst)
            // Request is registered first, giving the main path a settle cycle.
            L_IDLE: if (r_lreq && !w_full) w_lst_d = L_CAPT;
            L_CAPT: begin
                w_stage_d = bus.Ldata;
                w_wcnt_d  = '0;
                w_lst_d   = L_EVAL;
            end
            L_EVAL: begin
                if (w_all_res) begin
                    w_lst_d = w_any_err ? L_CORR : L_PUSH;
                end else if (r_wcnt == WLAST) begin
                    w_lst_d = L_CORR;
                    w_to_d  = 1'b1;
                end else begin
                    w_wcnt_d = r_wcnt + 1'b1;
                end
            end
            L_CORR: begin
                w_stage_d = bus.Sdata;
                w_inc     = 1'b1;
                w_lst_d   = L_PUSH;
            end
            L_PUSH: begin
                w_push   = 1'b1;
                w_lack_d = 1'b1;
                w_lst_d  = L_ACK;
            end
            L_ACK: begin
                if (!bus.Lreq) begin
                    w_lack_d = 1'b0;
                    w_lst_d  = L_IDLE;
                end
            end
            default: w_lst_d = L_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lst   <= L_IDLE;
            r_lreq  <= 1'b0;
            r_stage <= '0;
            r_wcnt  <= '0;
            r_lack  <= 1'b0;
            r_cap   <= 1'b0;
            r_smp   <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_lst   <= w_lst_d;
            r_lreq  <= bus.Lreq;
            r_stage <= w_stage_d;
            r_wcnt  <= w_wcnt_d;
            r_lack  <= w_lack_d;
            r_cap   <= (w_lst_d == L_CAPT);
            r_smp   <= (w_lst_d == L_CORR);
            r_to    <= w_to_d;
        end
    end

    // Clear takes priority over a coincident correction increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (bus.err_clr) begin
            r_cnt <= '0;
        end else if (w_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_rst_d   = r_rst;
        w_rreq_d  = r_rreq;
        w_rdata_d = r_rdata;
        w_pop     = 1'b0;
        case (r_rst)
            R_IDLE: begin
                if (!w_empty) begin
                    w_rdata_d = w_head;
                    w_pop     = 1'b1;
                    w_rreq_d  = 1'b1;
                    w_rst_d   = R_WAIT;
                end
            end
            R_WAIT: begin
                if (bus.Rack) begin
                    w_rreq_d = 1'b0;
                    w_rst_d  = R_RTZ;
                end
            end
            R_RTZ:   if (!bus.Rack) w_rst_d = R_IDLE;
            default: w_rst_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst   <= R_IDLE;
            r_rreq  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_rst   <= w_rst_d;
            r_rreq  <= w_rreq_d;
            r_rdata <= w_rdata_d;
        end
    end

    assign bus.Lack    = r_lack;
    assign bus.cap_en  = r_cap;
    assign bus.sample  = r_smp;
    assign bus.to_evt  = r_to;
    assign bus.err_cnt = r_cnt;
    assign bus.busy    = (r_lst != L_IDLE);
    assign bus.Rreq    = r_rreq;
    assign bus.Rdata   = r_rdata;
endmodule

// File: tb/tb_resilient_stage_ctrl.sv
// Scoreboard bench: the left driver queues expected words, a right-side monitor checks them.
module tb_resilient_stage_ctrl;
    localparam int unsigned ERR_WAIT = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;
    bit   rack_hold = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    resilient_stage_ctrl_if #(.WIDTH(32), .LANES(4), .CNT_W(2)) bus ();

    resilient_stage_ctrl #(
        .WIDTH    (32),
        .LANES    (4),
        .ERR_WAIT (ERR_WAIT),
        .DEPTH    (4),
        .CNT_W    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Right-side monitor: compares each presented word, then completes the 4-phase handshake.
    initial begin
        bus.Rack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && bus.Rreq && !rack_hold) begin
                if (exp_q.size() == 0) chk("rreq_unexpected", 64'(bus.Rreq), 64'd0);
                else chk("rdata", 64'(bus.Rdata), 64'(exp_q.pop_front()));
                bus.Rack = 1'b1;
                for (int i = 0; i < 20 && bus.Rreq; i++) @(negedge clk);
                if (bus.Rreq) chk("rreq_fall", 64'(bus.Rreq), 64'd0);
                bus.Rack = 1'b0;
            end
        end
    end

    // Called at a negedge; edge 0 is the next posedge.
    task automatic send(input logic [31:0] ld, input logic [31:0] sd, input logic [3:0] et,
                        input logic [3:0] ef, input int exp_lat, input int exp_smp,
                        input int exp_to, input bit clr_on_corr, output int e0);
        int n, lat, caps, smps, tos, both;
        n = -1; lat = -1; caps = 0; smps = 0; tos = 0; both = 0;
        bus.Ldata = ld; bus.Sdata = sd; bus.err_t = et; bus.err_f = ef; bus.Lreq = 1'b1;
        exp_q.push_back((exp_smp != 0) ? sd : ld);
        e0 = edge_cnt;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.cap_en) caps++;
            if (bus.sample) smps++;
            if (bus.to_evt) tos++;
            if (bus.cap_en && bus.sample) both++;
            if (bus.err_clr) bus.err_clr = 1'b0;
            if (clr_on_corr && bus.sample) bus.err_clr = 1'b1;
            if (bus.Lack) begin
                lat = n;
                break;
            end
        end
        chk("lack_latency", 64'(lat), 64'(exp_lat));
        chk("cap_en_pulses", 64'(caps), 64'd1);
        chk("sample_pulses", 64'(smps), 64'(exp_smp));
        chk("to_evt_pulses", 64'(tos), 64'(exp_to));
        chk("cap_sample_overlap", 64'(both), 64'd0);
        bus.Lreq = 1'b0; bus.err_t = '0; bus.err_f = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.Lack) break;
        end
        chk("lack_fall", 64'(bus.Lack), 64'd0);
        chk("busy_idle", 64'(bus.busy), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lack"},    64'(bus.Lack),    64'd0);
        chk({tag, "_rreq"},    64'(bus.Rreq),    64'd0);
        chk({tag, "_rdata"},   64'(bus.Rdata),   64'd0);
        chk({tag, "_cap_en"},  64'(bus.cap_en),  64'd0);
        chk({tag, "_sample"},  64'(bus.sample),  64'd0);
        chk({tag, "_to_evt"},  64'(bus.to_evt),  64'd0);
        chk({tag, "_busy"},    64'(bus.busy),    64'd0);
        chk({tag, "_err_cnt"}, 64'(bus.err_cnt), 64'd0);
    endtask

    initial begin
        int e0a, e0b, seen, lack_seen, busy_seen, cap_seen;
        bus.Lreq = 1'b0; bus.Ldata = '0; bus.Sdata = '0;
        bus.err_t = '0; bus.err_f = '0; bus.err_clr = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Clean token, then a back-to-back one to measure the left cycle.
        send(32'hA5A5_A5A5, 32'h0, 4'h0, 4'hF, 4, 0, 0, 1'b0, e0a);
        chk("err_cnt_clean", 64'(bus.err_cnt), 64'd0);
        send(32'h1234_5678, 32'h0, 4'h0, 4'hF, 4, 0, 0, 1'b0, e0b);
        chk("left_cycle", 64'(e0b - e0a), 64'd6);

        // Lane 2 flags an error: shadow value replaces the stage.
        send(32'h1, 32'h2, 4'b0100, 4'b1011, 5, 1, 0, 1'b0, e0a);
        chk("err_cnt_err", 64'(bus.err_cnt), 64'd1);

        // No lane resolves: timeout path.
        send(32'h3, 32'h55, 4'h0, 4'h0, 3 + ERR_WAIT + 1, 1, 1, 1'b0, e0a);
        chk("err_cnt_timeout", 64'(bus.err_cnt), 64'd2);

        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("err_cnt_clr", 64'(bus.err_cnt), 64'd0);

        for (int i = 0; i < 5; i++)
            send(32'h10 + i, 32'h20 + i, 4'b0001, 4'b1110, 5, 1, 0, 1'b0, e0a);
        chk("err_cnt_saturate", 64'(bus.err_cnt), 64'd3);

        send(32'h30, 32'h31, 4'b1000, 4'b0111, 5, 1, 0, 1'b1, e0a);
        chk("err_cnt_clr_wins", 64'(bus.err_cnt), 64'd0);

        // Backpressure: one word parks in Rdata, four fill the FIFO, the next is held off.
        rack_hold = 1'b1;
        for (int i = 0; i < 5; i++)
            send(32'h100 + i, 32'h0, 4'h0, 4'hF, 4, 0, 0, 1'b0, e0a);
        bus.Ldata = 32'h105; bus.err_f = 4'hF; bus.Lreq = 1'b1;
        exp_q.push_back(32'h105);
        lack_seen = 0; busy_seen = 0; cap_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.Lack) lack_seen++;
            if (bus.busy) busy_seen++;
            if (bus.cap_en) cap_seen++;
        end
        chk("full_no_lack", 64'(lack_seen), 64'd0);
        chk("full_not_busy", 64'(busy_seen), 64'd0);
        chk("full_no_capture", 64'(cap_seen), 64'd0);
        rack_hold = 1'b0;
        for (int i = 0; i < 200 && !bus.Lack; i++) @(negedge clk);
        chk("full_release_lack", 64'(bus.Lack), 64'd1);
        bus.Lreq = 1'b0; bus.err_f = '0;
        for (int i = 0; i < 20 && bus.Lack; i++) @(negedge clk);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_after_full", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 20 && (bus.Rreq || bus.Rack); i++) @(negedge clk);

        // Reset while evaluating, with one word in Rdata and one in the FIFO.
        rack_hold = 1'b1;
        send(32'hAAA1, 32'h0, 4'h0, 4'hF, 4, 0, 0, 1'b0, e0a);
        send(32'hAAA2, 32'hAAA3, 4'b0010, 4'b1101, 5, 1, 0, 1'b0, e0a);
        chk("pre_reset_err_cnt", 64'(bus.err_cnt), 64'd1);
        bus.Ldata = 32'hBAD; bus.Lreq = 1'b1;
        for (int i = 0; i < 20 && !bus.cap_en; i++) @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        #1 chk_all_zero("midreset");
        exp_q.delete();
        bus.Lreq = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rack_hold = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.Rreq) seen++;
        end
        chk("no_rreq_after_reset", 64'(seen), 64'd0);
        send(32'h600D, 32'h0, 4'h0, 4'hF, 4, 0, 0, 1'b0, e0a);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_final", 64'(exp_q.size()), 64'd0);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
